// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath: set-mode codes, the adjust FSM
// state encoding and the standard field moduli.
package clock_pkg;

    localparam logic [1:0] MODE_RUN       = 2'd0;
    localparam logic [1:0] MODE_SET_HOURS = 2'd1;
    localparam logic [1:0] MODE_SET_MIN   = 2'd2;
    localparam logic [1:0] MODE_SET_SEC   = 2'd3;

    localparam int MOD_SEC     = 60;
    localparam int MOD_HOUR_24 = 24;
    localparam int MOD_HOUR_12 = 12;

    typedef enum logic [1:0] {
        ADJ_IDLE   = 2'd0,
        ADJ_HOLD   = 2'd1,
        ADJ_REPEAT = 2'd2
    } adj_state_t;

endpackage

// File: rtl/time_field_counter_if.sv
// Control/status bundle of one time field: count/pacing strobes, set-bus load,
// adjust buttons, and the count with its carry/borrow flags.
interface time_field_counter_if #(parameter int WIDTH = 8);
    logic             Enable;
    logic             Tick;
    logic             load;
    logic [1:0]       mode;
    logic [WIDTH-1:0] value;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             BCO;

    modport master (output Enable, Tick, load, mode, value, inc, dec,
                    input  Q, RCO, BCO);
    modport slave  (input  Enable, Tick, load, mode, value, inc, dec,
                    output Q, RCO, BCO);
endinterface

// File: rtl/adjust_repeat.sv
// Button edge detect and press-and-hold FSM producing one-cycle step pulses.
// TIME_FIELD_AUTOREPEAT_EN adds Tick-paced auto-repeat; otherwise one step per press.
//
// state      | meaning
// ADJ_IDLE   | no button held, waiting for a fresh press edge
// ADJ_HOLD   | button held; counting Ticks toward the first repeat
// ADJ_REPEAT | auto-repeat running, one step every REPEAT_RATE Ticks
module adjust_repeat import clock_pkg::*; #(
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2
) (
    input  logic Clk,
    input  logic Clr,
    input  logic active,
`ifdef TIME_FIELD_AUTOREPEAT_EN
    input  logic tick,
`endif
    input  logic inc,
    input  logic dec,
    output logic step_up,
    output logic step_dn
);

    adj_state_t state, state_nx;
    logic inc_q, dec_q, armed, dir_up, dir_up_nx;
    logic press_up, press_dn, released;

    assign press_up = inc && !inc_q && !dec;
    assign press_dn = dec && !dec_q && !inc;
    assign released = dir_up ? !inc : !dec;

`ifdef TIME_FIELD_AUTOREPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW      = $clog2(CNT_MAX + 1);
    localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

    logic [TW-1:0] cnt, cnt_nx;
    logic          quiet, quiet_nx;

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cnt   <= '0;
            quiet <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            quiet <= quiet_nx;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state  <= ADJ_IDLE;
            inc_q  <= 1'b0;
            dec_q  <= 1'b0;
            armed  <= 1'b0;
            dir_up <= 1'b1;
        end else begin
            state  <= state_nx;
            inc_q  <= inc;
            dec_q  <= dec;
            armed  <= 1'b1;
            dir_up <= dir_up_nx;
        end
    end

    // A press seen on the first edge after reset is a button held through reset:
    // it is tracked to its release but never steps.
    always_comb begin
        state_nx  = state;
        dir_up_nx = dir_up;
        step_up   = 1'b0;
        step_dn   = 1'b0;
`ifdef TIME_FIELD_AUTOREPEAT_EN
        cnt_nx    = cnt;
        quiet_nx  = quiet;
`endif
        case (state)
            ADJ_IDLE: begin
                if (active && (press_up || press_dn)) begin
                    state_nx  = ADJ_HOLD;
                    dir_up_nx = press_up;
                    step_up   = press_up && armed;
                    step_dn   = press_dn && armed;
`ifdef TIME_FIELD_AUTOREPEAT_EN
                    cnt_nx    = '0;
                    quiet_nx  = !armed;
`endif
                end
            end
            default: begin
                if (!active || (inc && dec) || released) begin
                    state_nx = ADJ_IDLE;
`ifdef TIME_FIELD_AUTOREPEAT_EN
                    cnt_nx   = '0;
                end else if (tick && !quiet) begin
                    if (cnt == ((state == ADJ_HOLD) ? DLY_LAST : RATE_LAST)) begin
                        step_up  = dir_up;
                        step_dn  = !dir_up;
                        state_nx = ADJ_REPEAT;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + TW'(1);
                    end
`endif
                end
            end
        endcase
    end

endmodule

// File: rtl/time_field_counter.sv
// Modulo time-field counter with programmable lower bound, ripple carry/borrow,
// set-bus load and button adjust (auto-repeat under TIME_FIELD_AUTOREPEAT_EN).
module time_field_counter import clock_pkg::*; #(
    parameter int         WIDTH        = 8,
    parameter int         MODULUS      = MOD_SEC,
    parameter int         MIN_VALUE    = 0,
    parameter logic [1:0] FIELD_ID     = MODE_SET_MIN,
    parameter int         REPEAT_DELAY = 8,
    parameter int         REPEAT_RATE  = 2
) (
    input  logic Clk,
    input  logic Clr,
    time_field_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] Q_MIN = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] SPAN  = WIDTH'(MODULUS - 1 - MIN_VALUE);

    logic [WIDTH-1:0] q;
    logic             active, step_up, step_dn, in_range;

    assign active = (bus.mode == FIELD_ID);
    // Offset compare wraps values below MIN_VALUE to above SPAN.
    assign in_range = ((bus.value - Q_MIN) <= SPAN);

    adjust_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_adjust (
        .Clk     (Clk),
        .Clr     (Clr),
        .active  (active),
`ifdef TIME_FIELD_AUTOREPEAT_EN
        .tick    (bus.Tick),
`endif
        .inc     (bus.inc),
        .dec     (bus.dec),
        .step_up (step_up),
        .step_dn (step_dn)
    );

    function automatic logic [WIDTH-1:0] up_of(input logic [WIDTH-1:0] v);
        return (v == Q_MAX) ? Q_MIN : v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] dn_of(input logic [WIDTH-1:0] v);
        return (v == Q_MIN) ? Q_MAX : v - WIDTH'(1);
    endfunction

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            q <= Q_MIN;
        end else if (bus.load && active) begin
            q <= in_range ? bus.value : Q_MIN;
        end else if (active) begin
            if (step_up)      q <= up_of(q);
            else if (step_dn) q <= dn_of(q);
        end else if (bus.Enable) begin
            q <= up_of(q);
        end
    end

    assign bus.Q   = q;
    assign bus.RCO = (q == Q_MAX);
    assign bus.BCO = (q == Q_MIN);

endmodule

// File: tb/tb_time_field_counter.sv
// Scoreboard bench: a 0..59 minutes field and a 1..12 hours field share one clock.
module tb_time_field_counter;
    import clock_pkg::*;

    logic Clk = 1'b0;
    logic Clr;
    always #5 Clk = ~Clk;

    time_field_counter_if #(.WIDTH(8)) a_if ();
    time_field_counter_if #(.WIDTH(8)) b_if ();

    time_field_counter #(.WIDTH(8), .MODULUS(60), .MIN_VALUE(0), .FIELD_ID(MODE_SET_MIN),
                         .REPEAT_DELAY(8), .REPEAT_RATE(2))
        dut_a (.Clk(Clk), .Clr(Clr), .bus(a_if));
    time_field_counter #(.WIDTH(8), .MODULUS(13), .MIN_VALUE(1), .FIELD_ID(MODE_SET_HOURS),
                         .REPEAT_DELAY(8), .REPEAT_RATE(2))
        dut_b (.Clk(Clk), .Clr(Clr), .bus(b_if));

`ifdef TIME_FIELD_AUTOREPEAT_EN
    localparam int QA = 15;
`else
    localparam int QA = 11;
`endif

    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    exp_cyc[$];
    int    exp_sel[$];
    int    exp_q[$];
    bit    exp_rco[$];
    bit    exp_bco[$];
    string exp_name[$];

    task automatic push(input string nm, input int sel, input int q, input bit rco, input bit bco);
        exp_cyc.push_back(cyc + 1);
        exp_sel.push_back(sel);
        exp_q.push_back(q);
        exp_rco.push_back(rco);
        exp_bco.push_back(bco);
        exp_name.push_back(nm);
    endtask

    task automatic ea(input string nm, input int q);
        push(nm, 0, q, q == 59, q == 0);
    endtask

    task automatic eb(input string nm, input int q);
        push(nm, 1, q, q == 12, q == 1);
    endtask

    task automatic nx();
        @(negedge Clk);
    endtask

    task automatic ticks_a(input string nm, input int n, input int q);
        for (int i = 0; i < n; i++) begin
            a_if.Tick = 1'b1; ea(nm, q); nx();
            a_if.Tick = 1'b0; nx();
        end
    endtask

    // Monitor: compares every expectation due at this edge.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
                int    sel, q, due;
                bit    rco, bco;
                string nm;
                logic [7:0] aq;
                logic  arco, abco;
                due = exp_cyc.pop_front();
                sel = exp_sel.pop_front();
                q   = exp_q.pop_front();
                rco = exp_rco.pop_front();
                bco = exp_bco.pop_front();
                nm  = exp_name.pop_front();
                aq   = (sel == 0) ? a_if.Q   : b_if.Q;
                arco = (sel == 0) ? a_if.RCO : b_if.RCO;
                abco = (sel == 0) ? a_if.BCO : b_if.BCO;
                n_chk++;
                if (due != cyc || int'(aq) != q || arco !== rco || abco !== bco) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got Q=%0d RCO=%0b BCO=%0b, expected Q=%0d RCO=%0b BCO=%0b",
                             nm, cyc, aq, arco, abco, q, rco, bco);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rep_exp[14];
`ifdef TIME_FIELD_AUTOREPEAT_EN
        rep_exp = '{11, 11, 11, 11, 11, 11, 11, 12, 12, 13, 13, 14, 14, 15};
`else
        rep_exp = '{11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11};
`endif
        Clr = 1'b0;
        {a_if.Enable, a_if.Tick, a_if.load, a_if.inc, a_if.dec} = '0;
        {b_if.Enable, b_if.Tick, b_if.load, b_if.inc, b_if.dec} = '0;
        a_if.mode = MODE_RUN; a_if.value = '0;
        b_if.mode = MODE_RUN; b_if.value = '0;
        nx();
        ea("reset_a", 0); eb("reset_b", 1); nx();

        // Count to 37 then reset mid-count
        Clr = 1'b1; a_if.Enable = 1'b1;
        for (int i = 1; i <= 37; i++) begin ea("count_up", i); nx(); end
        Clr = 1'b0; ea("clr_mid_count", 0); eb("clr_mid_count_b", 1); nx();
        Clr = 1'b1; ea("resume_1", 1); nx();
        ea("resume_2", 2); nx();
        a_if.Enable = 1'b0;

        // Wrap and carry
        a_if.mode = MODE_SET_MIN; a_if.load = 1'b1; a_if.value = 8'd58; ea("load_58", 58); nx();
        a_if.load = 1'b0; a_if.mode = MODE_RUN; a_if.Enable = 1'b1; ea("carry_59", 59); nx();
        ea("wrap_0", 0); nx();
        a_if.load = 1'b1; a_if.value = 8'd30; ea("load_other_mode", 1); nx();
        a_if.load = 1'b0; a_if.Enable = 1'b0; ea("idle_hold", 1); nx();

        // Bounded 1..12 range
        b_if.mode = MODE_SET_HOURS; b_if.load = 1'b1; b_if.value = 8'd12; eb("b_load_12", 12); nx();
        b_if.load = 1'b0; b_if.mode = MODE_RUN; b_if.Enable = 1'b1; eb("b_wrap_to_1", 1); nx();
        b_if.Enable = 1'b0; b_if.mode = MODE_SET_HOURS; b_if.load = 1'b1; b_if.value = 8'd0;
        eb("b_load_below", 1); nx();
        b_if.value = 8'd13; eb("b_load_above", 1); nx();
        b_if.value = 8'd5; eb("b_load_5", 5); nx();
        b_if.load = 1'b0; b_if.mode = MODE_RUN;

        // Adjust down through the borrow, Enable ignored in set mode
        a_if.mode = MODE_SET_MIN; a_if.load = 1'b1; a_if.value = 8'd0; ea("load_0", 0); nx();
        a_if.load = 1'b0; a_if.Enable = 1'b1; a_if.dec = 1'b1; ea("dec_wrap", 59); nx();
        ea("dec_held", 59); nx();
        ea("dec_held", 59); nx();
        a_if.dec = 1'b0; ea("dec_release", 59); nx();
        a_if.dec = 1'b1; ea("dec_again", 58); nx();
        a_if.dec = 1'b0; a_if.Enable = 1'b0; ea("dec_release2", 58); nx();

        // Hold inc for 14 Ticks
        a_if.load = 1'b1; a_if.value = 8'd10; ea("load_10", 10); nx();
        a_if.load = 1'b0; a_if.inc = 1'b1; ea("inc_press", 11); nx();
        for (int t = 0; t < 14; t++) begin
            a_if.Tick = 1'b1; ea("inc_repeat", rep_exp[t]); nx();
            a_if.Tick = 1'b0; ea("inc_repeat_gap", rep_exp[t]); nx();
        end
        a_if.inc = 1'b0; a_if.Tick = 1'b1; ea("inc_release", QA); nx();
        a_if.Tick = 1'b0; nx();
        ticks_a("after_release", 3, QA);

        // inc and dec together abort the hold
        a_if.inc = 1'b1; ea("conflict_press", QA + 1); nx();
        a_if.dec = 1'b1; ea("conflict_both", QA + 1); nx();
        a_if.dec = 1'b0; ea("conflict_no_edge", QA + 1); nx();
        ticks_a("conflict_idle", 9, QA + 1);
        a_if.inc = 1'b0; ea("conflict_release", QA + 1); nx();

        // Mode leaves the field mid-hold
        a_if.inc = 1'b1; ea("mode_press", QA + 2); nx();
        a_if.mode = MODE_RUN; a_if.Enable = 1'b1; ea("mode_run_counts", QA + 3); nx();
        a_if.mode = MODE_SET_MIN; a_if.Enable = 1'b0; ea("mode_back_no_edge", QA + 3); nx();
        ticks_a("mode_idle", 9, QA + 3);
        a_if.inc = 1'b0; ea("mode_release", QA + 3); nx();

        // Press edge coinciding with load is consumed
        a_if.load = 1'b1; a_if.value = 8'd20; a_if.inc = 1'b1; ea("load_press", 20); nx();
        a_if.load = 1'b0; ea("load_press_held", 20); nx();
        a_if.inc = 1'b0; ea("load_press_release", 20); nx();

        // Reset mid-hold; held button must not step afterwards
        a_if.inc = 1'b1; ea("pre_clr_press", 21); nx();
        Clr = 1'b0; ea("clr_mid_hold", 0); eb("clr_mid_hold_b", 1); nx();
        Clr = 1'b1; ea("post_clr_held", 0); nx();
        ea("post_clr_held2", 0); nx();
        ticks_a("post_clr_ticks", 9, 0);
        a_if.inc = 1'b0; ea("post_clr_release", 0); nx();
        a_if.inc = 1'b1; ea("post_clr_repress", 1); nx();
        a_if.inc = 1'b0; ea("post_clr_done", 1); nx();

        nx(); nx();
        if (exp_cyc.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_cyc.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/time_field_counter.md
# time_field_counter

Parametrised modulo time-field counter for the clock datapath: one instance each for seconds, minutes and hours. It chains by ripple carry like the existing minutes counter. It adds a programmable lower bound (MIN_VALUE, e.g. 1..12 hours), a borrow output, and direct inc/dec adjustment with press-and-hold auto-repeat while its set mode is selected. Load from the set bus is kept.

## Interface
- WIDTH, 8, width of Q and value; MODULUS-1 < 2**WIDTH
- MODULUS, 60, count range upper limit (exclusive)
- MIN_VALUE, 0, count range lower limit (inclusive); MIN_VALUE < MODULUS
- FIELD_ID, 2, mode code that selects this field for load/adjust
- REPEAT_DELAY, 8, Tick pulses held before auto-repeat starts (≥1)
- REPEAT_RATE, 2, Tick pulses between repeat steps (≥1)

Ports:
- Clk  in  1  clock, rising edge
- Clr  in  1  reset, asynchronous, active-low
- Enable  in  1  count request (lower field carry / 1 Hz strobe)
- Tick  in  1  slow pacing strobe, one Clk wide
- load  in  1  load request
- mode  in  2  set-mode select
- value  in  WIDTH  load data
- inc  in  1  adjust-up button, debounced level
- dec  in  1  adjust-down button, debounced level
- Q  out  WIDTH  current count
- RCO  out  1  carry: Q == MODULUS-1 (combinational)
- BCO  out  1  borrow: Q == MIN_VALUE (combinational)

## Operation
- Legal range is MIN_VALUE..MODULUS-1. Every update wraps within that range:
  - up step from MODULUS-1 goes to MIN_VALUE
  - down step from MIN_VALUE goes to MODULUS-1
- Per-edge priority:
  1. Clr low
  2. load && mode==FIELD_ID: Q <= value. A value outside the range loads MIN_VALUE.
  3. Adjust step: only when mode==FIELD_ID and load=0.
  4. Enable && mode!=FIELD_ID: up step.
- While mode==FIELD_ID, Enable is ignored. The field is frozen except for adjust.
- load with mode!=FIELD_ID does nothing; Enable still counts that cycle.
- Adjust steps wrap silently. Neighbours see only the level of RCO/BCO.
- Adjust FSM, with one registered copy each of inc and dec:
  - IDLE: on press edge (inc=1 and inc_q=0, dec=0), step up and go to HOLD with tick count 0. dec behaves the same way with a down step.
  - HOLD: count Tick pulses. On the REPEAT_DELAY-th pulse, step in the held direction, go to REPEAT, and clear the count.
  - REPEAT: step on every REPEAT_RATE-th Tick pulse, then clear the count.
  - Any state goes to IDLE with no step when:
    - the held button is released,
    - inc and dec are both high, or
    - mode != FIELD_ID.
  - From IDLE, a new press needs a fresh edge.
  - A press edge while load=1 is consumed: the FSM enters HOLD, but no step is applied.
- The tick counter is $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1) bits.

## Timing
- Reset values: Q=MIN_VALUE, FSM=IDLE, tick count=0, inc_q/dec_q=0. BCO=1 and RCO=(MIN_VALUE==MODULUS-1).
- Load and Enable steps appear on Q at the same rising edge that samples the request, with 1-edge latency.
- The first adjust step lands on the edge that first samples the button high.
- First repeat step: the edge sampling the REPEAT_DELAY-th Tick after the press.
- Later repeat steps: every REPEAT_RATE Ticks after that.
- RCO and BCO follow Q combinationally, with zero cycles of latency.
- Clr low mid-hold aborts immediately. Q returns to MIN_VALUE. After Clr rises, a still-held button does not step until it is released and pressed again (inc_q is reset to 0, so this needs an explicit rule: the FSM enters HOLD with no step when the button is already high on the first post-reset edge).

## Configuration
- TIME_FIELD_AUTOREPEAT_EN defined: full IDLE/HOLD/REPEAT behaviour as above.
- Not defined:
  - The FSM reduces to IDLE/HOLD, and HOLD only waits for release.
  - Exactly one step per press edge.
  - Tick is unused, and the tick counter and the REPEAT_* logic are removed.
- Load, Enable, RCO and BCO are identical in both builds.

## Structure
- clock_pkg holds:
  - mode codes MODE_RUN=0, MODE_SET_HOURS=1, MODE_SET_MIN=2, MODE_SET_SEC=3
  - the adjust FSM state enum
  - the default MODULUS constants (60, 24, 12)
- One sub-module, adjust_repeat. It contains the edge detect, the FSM and the tick counter, and outputs one-cycle step_up/step_dn pulses. The parent does range and wrap arithmetic only.

## Test plan
- Reset mid-count: MODULUS=60, Enable held until Q=37, then Clr pulsed low → Q=0 immediately and BCO=1. Counting resumes 0,1,2 on Enable.
- Wrap and carry: MODULUS=60, Q=58, Enable for 2 edges → Q=59 with RCO=1, then Q=0 with RCO=0.
- Bounded range: MIN_VALUE=1, MODULUS=13, Q=12, Enable → Q=1. load value=0 with mode=FIELD_ID → Q=1 (out-of-range).
- Adjust down with borrow wrap: mode=FIELD_ID, Q=0, dec press → Q=59 on the first sampled-high edge. Enable pulses during this are ignored.
- Auto-repeat (macro on), DELAY=8, RATE=2: hold inc for 14 Tick pulses from Q=10 → Q=11 at press, 12 at Tick 8, then 13/14/15 at Ticks 10/12/14. Release → no further steps.
- Conflicts: inc and dec high together → no step and FSM goes to IDLE. Mode changed to MODE_RUN mid-hold → FSM goes to IDLE, and Enable counting resumes next edge.
